// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB digit first, with carry/borrow, half-carry and zero flags.
// Latency: start sampled at edge 0, done pulses in the cycle after edge N (N = WIDTH/DIGIT); busy for exactly N cycles.
// Backpressure: none; start is ignored while busy, and results hold until the next operation completes.
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4,
    parameter int HBIT  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             oc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             c_out,
    output logic             h_out,
    output logic             z_out
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
    // Digit whose carry-out is the carry out of bit HBIT-1
    localparam logic [CW-1:0] H_CNT    = CW'(HBIT / DIGIT - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic             last;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_nx;
    logic             op_r;
    // Internal carry is always an adder carry; for subtract it is the inverted borrow
    logic             carry_r;
    logic             h_r;
    logic [DIGIT-1:0] b_x;
    logic [DIGIT:0]   dsum;
    logic             cy_ext;

    assign last = (cnt == LAST_CNT);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: start only matters in IDLE, RUN leaves after the last digit
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state == RUN);
    end

    // One digit of a + b + c (subtract as a + ~b + ~borrow); new digit enters the result from the top
    always_comb begin
        b_x    = op_r ? ~b_sh[DIGIT-1:0] : b_sh[DIGIT-1:0];
        dsum   = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_x} + {{DIGIT{1'b0}}, carry_r};
        cy_ext = op_r ^ dsum[DIGIT];
        res_nx = (res_sh >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    // Operand capture, digit iteration, and result registers written only at completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            op_r    <= 1'b0;
            carry_r <= 1'b0;
            h_r     <= 1'b0;
            done    <= 1'b0;
            y       <= '0;
            c_out   <= 1'b0;
            h_out   <= 1'b0;
            z_out   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a_sh    <= a;
                    b_sh    <= b;
                    op_r    <= op;
                    carry_r <= op ^ (oc & c_in);
                    res_sh  <= '0;
                    cnt     <= '0;
                end
            end else begin
                a_sh    <= a_sh >> DIGIT;
                b_sh    <= b_sh >> DIGIT;
                carry_r <= dsum[DIGIT];
                res_sh  <= res_nx;
                cnt     <= cnt + 1'b1;
                if (cnt == H_CNT) begin
                    h_r <= cy_ext;
                end
                if (last) begin
                    cnt   <= '0;
                    done  <= 1'b1;
                    y     <= res_nx;
                    c_out <= cy_ext;
                    h_out <= (cnt == H_CNT) ? cy_ext : h_r;
                    z_out <= (res_nx == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial: 16-bit/4-bit-digit main instance plus a single-digit (N=1) instance.
// Latency: checks busy length, done timing and back-to-back issue against the operation protocol.
// Backpressure: not applicable; start-while-busy and mid-operation reset are exercised directly.
module tb_addsub_serial;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic        oc;
    logic        c_in;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy, done, c_out, h_out, z_out;
    logic [15:0] y;
    logic        busy1, done1, c1, h1, z1;
    logic [15:0] y1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(16), .DIGIT(4), .HBIT(4)) u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .oc(oc),
        .a(a), .b(b), .c_in(c_in),
        .busy(busy), .done(done), .y(y), .c_out(c_out), .h_out(h_out), .z_out(z_out)
    );

    addsub_serial #(.WIDTH(16), .DIGIT(16), .HBIT(16)) u_dut_n1 (
        .clk(clk), .reset(reset), .start(start), .op(op), .oc(oc),
        .a(a), .b(b), .c_in(c_in),
        .busy(busy1), .done(done1), .y(y1), .c_out(c1), .h_out(h1), .z_out(z1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference arithmetic on plain integers: returns {c, h, z, y}
    function automatic logic [18:0] model(input logic o, input logic occ, input logic ci,
                                          input logic [15:0] aa, input logic [15:0] bb, input int hb);
        int unsigned e, ai, bi, mask, s;
        logic [15:0] yy;
        logic        c, h;
        e    = (occ & ci) ? 1 : 0;
        ai   = aa;
        bi   = bb;
        mask = (32'd1 << hb) - 1;
        if (!o) begin
            s  = ai + bi + e;
            c  = (s > 65535);
            h  = (((ai & mask) + (bi & mask) + e) > mask);
            yy = s[15:0];
        end else begin
            c  = (ai < bi + e);
            h  = ((ai & mask) < (bi & mask) + e);
            s  = ai - bi - e;
            yy = s[15:0];
        end
        return {c, h, (yy == 16'h0000), yy};
    endfunction

    // Issue one operation (called at posedge+1) and wait for done; lat = edges after the start edge
    task automatic do_op(input logic o, input logic occ, input logic ci,
                         input logic [15:0] aa, input logic [15:0] bb,
                         output int lat, output int bcnt);
        op = o; oc = occ; c_in = ci; a = aa; b = bb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 50) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 50) check("done_timeout", 32'(lat), 32'd4);
    endtask

    int          lat, bcnt, dones;
    logic [18:0] exp_v;
    logic [15:0] vb;

    initial begin
        reset = 1'b1; start = 1'b0; op = 1'b0; oc = 1'b0; c_in = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res",  32'({c_out, h_out, z_out, y}), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // add 0x1234 + 0x0FFF
        do_op(1'b0, 1'b0, 1'b0, 16'h1234, 16'h0FFF, lat, bcnt);
        check("add_lat",  32'(lat), 32'd4);
        check("add_busy", 32'(bcnt), 32'd4);
        check("add_busy_at_done", 32'(busy), 32'd0);
        check("add_res", 32'({c_out, h_out, z_out, y}), 32'({1'b0, 1'b1, 1'b0, 16'h2233}));
        @(posedge clk); #1;
        check("done_pulse_one", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("res_hold", 32'(y), 32'h2233);

        // sub 0x0000 - 0x0001
        do_op(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0001, lat, bcnt);
        check("sub_res", 32'({c_out, h_out, z_out, y}), 32'({1'b1, 1'b1, 1'b0, 16'hFFFF}));
        // 0xFFFF + 0 with c_in, oc on then off (back-to-back from done cycle)
        do_op(1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0000, lat, bcnt);
        check("b2b_lat", 32'(lat), 32'd4);
        check("adc_oc1", 32'({c_out, h_out, z_out, y}), 32'({1'b1, 1'b1, 1'b1, 16'h0000}));
        do_op(1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, lat, bcnt);
        check("adc_oc0", 32'({c_out, h_out, z_out, y}), 32'({1'b0, 1'b0, 1'b0, 16'hFFFF}));
        // 0x8000 - 0x7FFF - 1
        do_op(1'b1, 1'b1, 1'b1, 16'h8000, 16'h7FFF, lat, bcnt);
        check("sbb_res", 32'({c_out, h_out, z_out, y}), 32'({1'b0, 1'b1, 1'b1, 16'h0000}));

        // start pulsed and operands changed while busy
        @(posedge clk); #1;
        op = 1'b0; oc = 1'b0; a = 16'h1111; b = 16'h2222; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a = 16'hFFFF; b = 16'hFFFF; op = 1'b1; oc = 1'b1; c_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                dones++;
                check("busy_ignore_res", 32'(y), 32'h3333);
            end
            @(posedge clk); #1;
        end
        check("busy_ignore_dones", 32'(dones), 32'd1);

        // reset in busy cycle 2 aborts with immediate clear
        op = 1'b0; oc = 1'b0; a = 16'h1234; b = 16'h0001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_res", 32'({done, c_out, h_out, z_out, y}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) dones++;
            @(posedge clk); #1;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        do_op(1'b0, 1'b0, 1'b0, 16'h0001, 16'h0001, lat, bcnt);
        check("post_reset_lat", 32'(lat), 32'd4);
        check("post_reset_res", 32'(y), 32'h0002);

        // single-digit instance: busy one cycle, done the next
        @(posedge clk); #1;
        op = 1'b0; oc = 1'b0; a = 16'h00FF; b = 16'h0001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("n1_busy", 32'({busy1, done1}), 32'b10);
        @(posedge clk); #1;
        check("n1_done", 32'({busy1, done1}), 32'b01);
        check("n1_res", 32'({c1, h1, z1, y1}), 32'({1'b0, 1'b0, 1'b0, 16'h0100}));
        repeat (6) @(posedge clk);
        #1;

        // back-to-back sweep against the integer model, both widths of digit
        for (int av = 0; av <= 16'hFFFF; av += 50) begin
            vb = 16'((av * 3 + 7) & 16'hFFFF);
            op = (av / 50) % 2;
            oc = $urandom_range(1);
            c_in = $urandom_range(1);
            exp_v = model(op, oc, c_in, 16'(av), vb, 4);
            do_op(op, oc, c_in, 16'(av), vb, lat, bcnt);
            check("sweep_d4", 32'({c_out, h_out, z_out, y}), 32'(exp_v));
            exp_v = model(op, oc, c_in, 16'(av), vb, 16);
            check("sweep_d16", 32'({c1, h1, z1, y1}), 32'(exp_v));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/addsub_serial.md
ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, the operand/result width in bits.
REQ-002 The module SHALL have parameter DIGIT, default 4, the bits processed per cycle; WIDTH SHALL be a multiple of DIGIT.
REQ-003 The module SHALL have parameter HBIT, default 4, the half-carry position; HBIT SHALL be a multiple of DIGIT, 0 < HBIT <= WIDTH.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request; sampled only in IDLE.
REQ-007 op  input  1  0: add, 1: subtract.
REQ-008 oc  input  1  1: include c_in (add-with-carry / subtract-with-borrow); 0: c_in ignored.
REQ-009 a, b  input  WIDTH each  operands.
REQ-010 c_in  input  1  carry/borrow in.
REQ-011 busy  output  1  high while digits are being processed.
REQ-012 done  output  1  one-cycle pulse, result valid.
REQ-013 y  output  WIDTH  result.
REQ-014 c_out, h_out, z_out  output  1 each  carry/borrow out of bit WIDTH-1, out of bit HBIT-1, result-is-zero.

Function
REQ-015 Add: y = (a + b + (oc & c_in)) mod 2^WIDTH; c_out = carry out of bit WIDTH-1.
REQ-016 Sub: y = (a - b - (oc & c_in)) mod 2^WIDTH; c_out = 1 iff a < b + (oc & c_in) (borrow).
REQ-017 h_out SHALL equal the carry (add) or borrow (sub) out of bit HBIT-1 under the same rule on the low HBIT bits.
REQ-018 z_out SHALL be 1 iff y == 0, independent of oc.
REQ-019 States: IDLE, RUN; N = WIDTH/DIGIT digits.
REQ-020 IDLE with start=1 at an edge: capture a, b, op, effective carry (oc & c_in); go RUN; digit counter = 0; busy=1 next cycle.
REQ-021 RUN: each edge processes digit k (bits k*DIGIT..k*DIGIT+DIGIT-1), LSB digit first, propagating carry/borrow to next digit; counter increments.
REQ-022 On the edge processing digit N-1: go IDLE, busy=0, done=1 for exactly one cycle; y, c_out, h_out, z_out valid from that cycle.
REQ-023 Latency: start sampled at edge 0 -> done high in the cycle after edge N; busy high for exactly N cycles.
REQ-024 N=1 (WIDTH==DIGIT) SHALL work: busy one cycle, done the following cycle.
REQ-025 start while busy SHALL be ignored, not queued.
REQ-026 start in the done cycle (state IDLE) SHALL be accepted; back-to-back operations every N+1 cycles.
REQ-027 Changes on a, b, op, oc, c_in while busy SHALL NOT affect the result.
REQ-028 y, c_out, h_out, z_out SHALL hold their values until the next accepted operation's done; they SHALL NOT glitch to partial values while busy (result register updated only at completion).

Reset
REQ-029 reset=1 SHALL immediately force state IDLE, busy=0, done=0, y=0, c_out=0, h_out=0, z_out=0, counter=0.
REQ-030 reset mid-operation SHALL abort it with no done pulse; first start after reset release SHALL behave as from power-up.

Verification (WIDTH=16, DIGIT=4, HBIT=4)
REQ-031 add, oc=0, a=0x1234, b=0x0FFF, start at edge 0 -> busy 4 cycles, done after edge 4; y=0x2233, c_out=0, h_out=1, z_out=0.
REQ-032 sub, oc=0, a=0x0000, b=0x0001 -> y=0xFFFF, c_out=1, h_out=1, z_out=0.
REQ-033 add, a=0xFFFF, b=0x0000, c_in=1: oc=1 -> y=0x0000, c_out=1, h_out=1, z_out=1; oc=0 -> y=0xFFFF, c_out=0, h_out=0, z_out=0.
REQ-034 sub, oc=1, c_in=1, a=0x8000, b=0x7FFF -> y=0x0000, c_out=0, h_out=1, z_out=1.
REQ-035 start pulsed and a/b changed during busy -> no effect, single done, original result; reset at busy cycle 2 -> all outputs 0 at once, no done; next start (0x0001+0x0001) -> y=0x0002.
REQ-036 back-to-back starts in each done cycle, a,b stepping 0..0xFFFF by 50, both ops, random oc/c_in -> every result matches REQ-015..018 golden model; repeat with DIGIT=1, 8, 16.
